// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the adder/subtractor result buffer.
// Entry layout (LSB first): q[DW-1:0], flags {V,C,N,Z}, ctrl.
package addsub_pkg;

   localparam int ADDSUB_DW = 4;
   localparam int FLG_W     = 4;
   localparam int ENTRY_W   = ADDSUB_DW + FLG_W + 1;

   // Bit positions inside the 4-bit flag field
   localparam int FLG_Z = 0;
   localparam int FLG_N = 1;
   localparam int FLG_C = 2;
   localparam int FLG_V = 3;

   // Entry slice positions for an arbitrary result width
   function automatic int entry_w(int dw);
      return dw + FLG_W + 1;
   endfunction

   function automatic int flg_lsb(int dw);
      return dw;
   endfunction

   function automatic int ctrl_bit(int dw);
      return dw + FLG_W;
   endfunction

endpackage

// File: rtl/addsub_flag_gen.sv
// Combinational Z/N/C/V generator from a result and the top two carry-chain bits.
module addsub_flag_gen
   import addsub_pkg::*;
#(
   parameter int DW = ADDSUB_DW
) (
   input  logic [DW-1:0]    q,
   input  logic [1:0]       cout_hi,
   output logic [FLG_W-1:0] flags
);

   // cout_hi = {final carry, carry into the MSB stage}
   always_comb begin
      flags        = '0;
      flags[FLG_Z] = (q == '0);
      flags[FLG_N] = q[DW-1];
      flags[FLG_C] = cout_hi[1];
      flags[FLG_V] = cout_hi[1] ^ cout_hi[0];
   end

endmodule

// File: rtl/addsub_result_buffer.sv
// Valid/ready FIFO for adder/subtractor results with derived status flags.
// Define ADDSUB_STATS_EN to add the ovf_count and drop_seen status outputs.
module addsub_result_buffer
   import addsub_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = ADDSUB_DW
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DW-1:0]            in_q,
   input  logic [DW-1:0]            in_cout,
   input  logic                     in_ctrl,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DW-1:0]            out_q,
   output logic [FLG_W-1:0]         out_flags,
   output logic                     out_ctrl,
   output logic [$clog2(DEPTH):0]   count
`ifdef ADDSUB_STATS_EN
   ,
   output logic [7:0]               ovf_count,
   output logic [0:0]               drop_seen
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = entry_w(DW);
   localparam int FL = flg_lsb(DW);
   localparam int CB = ctrl_bit(DW);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [EW-1:0]    mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic [FLG_W-1:0] in_flags;
   logic [EW-1:0]    entry_in;
   logic [EW-1:0]    head;
   logic             push;
   logic             pop;
   logic             unused_cout;

   // Only the top two carries matter; the rest of the chain is informational
   assign unused_cout = ^in_cout;

   addsub_flag_gen #(
      .DW      (DW)
   ) u_flag_gen (
      .q       (in_q),
      .cout_hi (in_cout[DW-1 -: 2]),
      .flags   (in_flags)
   );

   assign entry_in  = {in_ctrl, in_flags, in_q};
   assign in_ready  = (count_reg != FULL_CNT);
   assign out_valid = (count_reg != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign count     = count_reg;

   // First-word fall-through; outputs forced to zero while empty
   assign head      = mem_reg[rd_ptr_reg];
   assign out_q     = out_valid ? head[DW-1:0]  : '0;
   assign out_flags = out_valid ? head[CB-1:FL] : '0;
   assign out_ctrl  = out_valid ? head[CB]      : 1'b0;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_next;
      end
   end

   // Storage needs no reset: contents are invisible until count says otherwise
   always_ff @(posedge clk) begin
      if (push) begin
         mem_reg[wr_ptr_reg] <= entry_in;
      end
   end

`ifdef ADDSUB_STATS_EN
   logic [7:0] ovf_count_reg;
   logic       drop_seen_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count_reg <= '0;
         drop_seen_reg <= 1'b0;
      end else begin
         if (push && in_flags[FLG_V] && (ovf_count_reg != 8'hff)) begin
            ovf_count_reg <= ovf_count_reg + 8'd1;
         end
         if (in_valid && !in_ready) begin
            drop_seen_reg <= 1'b1;
         end
      end
   end

   assign ovf_count = ovf_count_reg;
   assign drop_seen = drop_seen_reg;
`endif

endmodule

// File: tb/tb_addsub_result_buffer.sv
// Randomized scoreboard bench for addsub_result_buffer (DEPTH=4, DW=4).
// Covers ADDSUB_STATS_EN outputs when the macro is defined.
module tb_addsub_result_buffer;

   localparam int DEPTH = 4;
   localparam int DW    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_q = '0;
   logic [DW-1:0] in_cout = '0;
   logic          in_ctrl = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_q;
   logic [3:0]    out_flags;
   logic          out_ctrl;
   logic [2:0]    count;
`ifdef ADDSUB_STATS_EN
   logic [7:0]    ovf_count;
   logic [0:0]    drop_seen;
`endif

   addsub_result_buffer #(
      .DEPTH     (DEPTH),
      .DW        (DW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_q      (in_q),
      .in_cout   (in_cout),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_q     (out_q),
      .out_flags (out_flags),
      .out_ctrl  (out_ctrl),
      .count     (count)
`ifdef ADDSUB_STATS_EN
      ,
      .ovf_count (ovf_count),
      .drop_seen (drop_seen)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int q;
      int flags;
      int ctrl;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   model_ovf = 0;
   bit   model_drop = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Flags straight from the arithmetic meaning of q and the carry chain
   function automatic int ref_flags(input int q, input int cout);
      int z, n, c, v;
      z = (q == 0) ? 1 : 0;
      n = (q >= (1 << (DW - 1))) ? 1 : 0;
      c = (cout >> (DW - 1)) & 1;
      v = ((cout >> (DW - 1)) ^ (cout >> (DW - 2))) & 1;
      return v * 8 + c * 4 + n * 2 + z;
   endfunction

   // Monitor / scoreboard: checks current state, then advances the model
   always @(negedge clk) begin
      int   sz;
      exp_t e;
      if (!rst_n) begin
         sb.delete();
         model_ovf  = 0;
         model_drop = 1'b0;
         check("rst_count", count, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 1);
      end else begin
         sz = sb.size();
         check("count", count, sz);
         check("in_ready", in_ready, (sz != DEPTH) ? 1 : 0);
         check("out_valid", out_valid, (sz != 0) ? 1 : 0);
`ifdef ADDSUB_STATS_EN
         check("ovf_count", ovf_count, model_ovf);
         check("drop_seen", drop_seen, model_drop);
`endif
         if (sz == 0) begin
            check("empty_q", out_q, 0);
            check("empty_flags", out_flags, 0);
            check("empty_ctrl", out_ctrl, 0);
         end else begin
            check("head_q", out_q, sb[0].q);
            check("head_flags", out_flags, sb[0].flags);
            check("head_ctrl", out_ctrl, sb[0].ctrl);
            if (out_ready) begin
               e = sb.pop_front();
            end
         end
         if (in_valid && sz != DEPTH) begin
            e.q     = int'(in_q);
            e.flags = ref_flags(int'(in_q), int'(in_cout));
            e.ctrl  = int'(in_ctrl);
            sb.push_back(e);
            if (e.flags >= 8 && model_ovf < 255) begin
               model_ovf++;
            end
         end
         if (in_valid && sz == DEPTH) begin
            model_drop = 1'b1;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_one(input int q, input int cout, input bit ctrl);
      int n;
      bit acc;
      n   = 0;
      acc = 1'b0;
      in_q     = q[DW-1:0];
      in_cout  = cout[DW-1:0];
      in_ctrl  = ctrl;
      in_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check("push_accept", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic push_rand();
      push_one(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (count != 0 && n < 100) begin
         cycles(1);
         n++;
      end
      check("wait_empty", count, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int cv;

      // Reset state
      rst_n = 1'b0;
      cycles(3);
      check("reset_out_q", out_q, 0);
      check("reset_out_flags", out_flags, 0);
      rst_n = 1'b1;
      cycles(1);

      // Directed: 5 + 3 and 3 - 3
      out_ready = 1'b1;
      push_one(8, 7, 1'b0);
      check("add_valid", out_valid, 1);
      check("add_q", out_q, 8);
      check("add_flags", out_flags, 4'b1010);
      check("add_ctrl", out_ctrl, 0);
      cycles(1);
      push_one(0, 15, 1'b1);
      check("sub_q", out_q, 0);
      check("sub_flags", out_flags, 4'b0101);
      check("sub_ctrl", out_ctrl, 1);
      cycles(1);
      wait_empty();

      // Fill to DEPTH, attempt an extra push, then drain
      out_ready = 1'b0;
      repeat (DEPTH) push_rand();
      check("fill_count", count, DEPTH);
      check("fill_in_ready", in_ready, 0);
      in_q     = 4'd9;
      in_valid = 1'b1;
      cycles(3);
      in_valid = 1'b0;
      check("overflow_count", count, DEPTH);
`ifdef ADDSUB_STATS_EN
      check("fill_drop_seen", drop_seen, 1);
`endif
      out_ready = 1'b1;
      cycles(DEPTH);
      check("drain_count", count, 0);

      // Steady push+pop at count = 2
      out_ready = 1'b0;
      repeat (2) push_rand();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_q    = 4'($urandom_range(0, 15));
         in_cout = 4'($urandom_range(0, 15));
         in_ctrl = 1'($urandom_range(0, 1));
         cycles(1);
         check("steady_count", count, 2);
      end
      in_valid = 1'b0;
      wait_empty();

      // Random traffic with upstream holding data until accepted
      acc = 1'b1;
      for (int i = 0; i < 400; i++) begin
         out_ready = 1'($urandom_range(0, 3) != 0 ? 1 : 0);
         if (!in_valid || acc) begin
            in_q     = 4'($urandom_range(0, 15));
            in_cout  = 4'($urandom_range(0, 15));
            in_ctrl  = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 2) != 0 ? 1 : 0);
         end
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_empty();

      // Asynchronous reset mid-stream with three entries held
      out_ready = 1'b0;
      repeat (3) push_rand();
      check("pre_reset_count", count, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_count", count, 0);
      check("async_in_ready", in_ready, 1);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      cycles(2);
      check("post_reset_valid", out_valid, 0);
      out_ready = 1'b1;
      push_one(5, 2, 1'b0);
      check("post_reset_q", out_q, 5);
      cycles(2);
      check("post_reset_count", count, 0);

      // 300 pushes that each report signed overflow
      for (int i = 0; i < 300; i++) begin
         cv = int'($urandom_range(0, 3)) | (($urandom_range(0, 1) != 0) ? 8 : 4);
         push_one(int'($urandom_range(0, 15)), cv, 1'($urandom_range(0, 1)));
      end
      cycles(2);
`ifdef ADDSUB_STATS_EN
      check("ovf_saturate", ovf_count, 255);
`endif

      // Push while full: sticky drop indication survives draining
      out_ready = 1'b0;
      repeat (DEPTH) push_rand();
      in_valid = 1'b1;
      cycles(1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycles(10);
`ifdef ADDSUB_STATS_EN
      check("drop_held", drop_seen, 1);
`endif
      check("final_count", count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
